// File: rtl/bcd_counter_chain.sv
// ============================================================================
// Module   : bcd_counter_chain
// Purpose  : Synchronous cascade of BCD digit counters. Counts up or down and
//            loads in parallel with digit validation. Flags terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter_chain #(
  parameter int DIGITS   = 2,
  parameter int LAST_MAX = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tc,
  output logic                  load_err
);

  localparam logic [3:0] c_top_max = 4'(LAST_MAX);

  logic [4*DIGITS-1:0] r_bcd;
  logic                r_load_err;
  logic [4*DIGITS-1:0] w_next;
  logic [DIGITS-1:0]   w_at_term;
  logic [DIGITS-1:0]   w_step;
  logic [DIGITS-1:0]   w_ld_ok;
  logic                w_load_valid;

  // A digit steps only when every digit below it sits at its terminal value.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      localparam logic [3:0] c_max = (i == DIGITS - 1) ? c_top_max : 4'd9;

      logic [3:0] w_digit;
      logic [3:0] w_ld_digit;

      assign w_digit      = r_bcd[4*i +: 4];
      assign w_ld_digit   = load_value[4*i +: 4];
      assign w_ld_ok[i]   = (w_ld_digit <= c_max);
      assign w_at_term[i] = up_down ? (w_digit == c_max) : (w_digit == 4'd0);

      if (i == 0) begin : g_first
        assign w_step[i] = enable & ~load;
      end else begin : g_rest
        assign w_step[i] = w_step[i-1] & w_at_term[i-1];
      end

      always_comb begin
        w_next[4*i +: 4] = w_digit;
        if (w_step[i]) begin
          if (up_down) begin
            w_next[4*i +: 4] = w_at_term[i] ? 4'd0 : w_digit + 4'd1;
          end else begin
            w_next[4*i +: 4] = w_at_term[i] ? c_max : w_digit - 4'd1;
          end
        end
      end
    end
  endgenerate

  assign w_load_valid = &w_ld_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bcd      <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (load) begin
        // A rejected load leaves the count untouched.
        if (w_load_valid) begin
          r_bcd <= load_value;
        end else begin
          r_load_err <= 1'b1;
        end
      end else begin
        r_bcd <= w_next;
      end
    end
  end

  assign bcd      = r_bcd;
  assign load_err = r_load_err;
  assign tc       = w_step[DIGITS-1] & w_at_term[DIGITS-1];

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench: driver pushes the expected view of each cycle, monitor
// compares it on the falling edge. Covers a 2-digit/5 and a 4-digit/2 instance.
`default_nettype none

module tb_bcd_counter_chain;

  typedef struct {
    logic [15:0] bcd;
    logic        tc;
    logic        err;
    bit          wide;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   drv_done = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        en_n = 1'b0, ud_n = 1'b1, ld_n = 1'b0;
  logic [7:0]  lv_n = '0;
  logic [7:0]  bcd_n;
  logic        tc_n, err_n;

  logic        en_w = 1'b0, ud_w = 1'b1, ld_w = 1'b0;
  logic [15:0] lv_w = '0;
  logic [15:0] bcd_w;
  logic        tc_w, err_w;

  bcd_counter_chain #(.DIGITS(2), .LAST_MAX(5)) dut_n (
    .clock(clock), .reset(reset), .enable(en_n), .up_down(ud_n),
    .load(ld_n), .load_value(lv_n), .bcd(bcd_n), .tc(tc_n), .load_err(err_n)
  );

  bcd_counter_chain #(.DIGITS(4), .LAST_MAX(2)) dut_w (
    .clock(clock), .reset(reset), .enable(en_w), .up_down(ud_w),
    .load(ld_w), .load_value(lv_w), .bcd(bcd_w), .tc(tc_w), .load_err(err_w)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Drive one cycle (entered at posedge+1) and queue what it must look like.
  task automatic cyc(input bit wide, input logic en, input logic ud,
                     input logic ld, input logic [15:0] lv,
                     input logic [15:0] eb, input logic et, input logic ee,
                     input string nm);
    exp_t e;
    if (wide) begin
      en_w = en; ud_w = ud; ld_w = ld; lv_w = lv;
      en_n = 1'b0; ld_n = 1'b0;
    end else begin
      en_n = en; ud_n = ud; ld_n = ld; lv_n = lv[7:0];
      en_w = 1'b0; ld_w = 1'b0;
    end
    e.bcd = eb; e.tc = et; e.err = ee; e.wide = wide; e.name = nm;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input bit wide, input logic [15:0] eb,
                          input logic et, input logic ee, input string nm);
    exp_t e;
    e.bcd = eb; e.tc = et; e.err = ee; e.wide = wide; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: the outputs are presented every cycle; compare all queued entries.
  always @(negedge clock) begin
    exp_t e;
    logic [15:0] ab;
    logic at, ae;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ab = e.wide ? bcd_w : {8'h00, bcd_n};
      at = e.wide ? tc_w : tc_n;
      ae = e.wide ? err_w : err_n;
      n_checks++;
      if (ab !== e.bcd || at !== e.tc || ae !== e.err) begin
        n_errors++;
        $display("FAIL %s: got bcd=%h tc=%b load_err=%b, expected bcd=%h tc=%b load_err=%b",
                 e.name, ab, at, ae, e.bcd, e.tc, e.err);
      end
    end
  end

  initial begin
    int v;
    @(posedge clock);
    #1;
    push_exp(1'b0, 16'h0000, 1'b0, 1'b0, "reset_state_n");
    push_exp(1'b1, 16'h0000, 1'b0, 1'b0, "reset_state_w");
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 60; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, to_bcd(i), (i == 59), 1'b0, "up_wrap");

    // Down from 00 wraps to 59; the 00 cycles carry tc.
    for (int k = 0; k < 62; k++) begin
      v = (120 - k) % 60;
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, to_bcd(v), (v == 0), 1'b0, "down_wrap");
    end

    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h59, 16'h58, 1'b0, 1'b0, "load_59");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h37, 16'h59, 1'b0, 1'b0, "load_prio_tc");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h37, 1'b0, 1'b0, "load_37");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h38, 1'b0, 1'b0, "count_38");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h39, 1'b0, 1'b0, "count_39");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h40, 1'b0, 1'b0, "count_40_dir_dn");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h39, 1'b0, 1'b0, "dir_dn_39");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h40, 1'b0, 1'b0, "dir_up_40");

    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h12, 16'h40, 1'b0, 1'b0, "hold_40");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h6A, 16'h12, 1'b0, 1'b0, "bad_load_6A");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  16'h12, 1'b0, 1'b1, "err_pulse_6A");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  16'h12, 1'b0, 1'b0, "err_clear_6A");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h60, 16'h12, 1'b0, 1'b0, "bad_load_60");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  16'h12, 1'b0, 1'b1, "err_pulse_60");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  16'h12, 1'b0, 1'b0, "err_clear_60");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h6A, 16'h12, 1'b0, 1'b0, "bad_load_b2b_a");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0F, 16'h12, 1'b0, 1'b1, "bad_load_b2b_b");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  16'h12, 1'b0, 1'b1, "err_b2b_hold");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  16'h12, 1'b0, 1'b0, "err_b2b_clear");

    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h25, 16'h12, 1'b0, 1'b0, "load_25");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0,  16'h25, 1'b0, 1'b0, "count_26");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h6A, 16'h26, 1'b0, 1'b0, "bad_load_pre_rst");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0,  16'h26, 1'b0, 1'b1, "count_27_err");

    // Reset lands between edges while counting with load_err high.
    en_n = 1'b1; ud_n = 1'b1; ld_n = 1'b0;
    #2;
    reset = 1'b1;
    push_exp(1'b0, 16'h0000, 1'b0, 1'b0, "async_reset");
    @(posedge clock);
    #1;
    push_exp(1'b0, 16'h0000, 1'b0, 1'b0, "reset_held");
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h00, 1'b0, 1'b0, "resume_00");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h01, 1'b0, 1'b0, "resume_01");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h02, 1'b0, 1'b0, "resume_02");

    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h2999, 16'h0000, 1'b0, 1'b0, "w_load_2999");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0,    16'h2999, 1'b1, 1'b0, "w_tc_2999");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0,    16'h0000, 1'b0, 1'b0, "w_wrap_0000");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0, "w_load_0100");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    16'h0100, 1'b0, 1'b0, "w_at_0100");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    16'h0099, 1'b0, 1'b0, "w_down_0099");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0098, 1'b0, 1'b0, "w_down_0098");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h3000, 16'h0098, 1'b0, 1'b0, "w_bad_3000");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0098, 1'b0, 1'b1, "w_err_3000");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    16'h0000, 1'b1, 1'b0, "w_tc_down");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0,    16'h2999, 1'b0, 1'b0, "w_wrap_2999");

    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!drv_done && budget < 2000) begin
      @(posedge clock);
      budget++;
    end
    if (!drv_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL driver_timeout: got cycles=%0d, expected completion within 2000", budget);
    end
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
